// File: rtl/babbage_pkg.sv
// Shared constants, widths and state encoding for the Babbage difference
// engine family (forward engine and babbage_inverse).
//   F0/G1/H2/C : recurrence seeds for f(n) = n^3 + 2n^2 + 2n + 1
//   N_MAX/F_MAX: last index and f(N_MAX)
//   F_W/N_W    : value and index widths
//   state_e    : idle/op/done encoding
package babbage_pkg;

    localparam int unsigned F_W = 18;
    localparam int unsigned N_W = 6;

    localparam logic [F_W-1:0] F0    = 18'd1;
    localparam logic [F_W-1:0] G1    = 18'd5;
    localparam logic [F_W-1:0] H2    = 18'd10;
    localparam logic [F_W-1:0] C     = 18'd6;
    localparam logic [F_W-1:0] F_MAX = 18'd258112;
    localparam logic [N_W-1:0] N_MAX = 6'd63;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OP   = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/babbage_step.sv
// Combinational forward-difference stepper: given the current f/g/h and
// the index being stepped to (n_next), produce the differences at n_next.
//   n_next          in  N_W  index after the step
//   f_in/g_in/h_in  in  F_W  values at n_next-1
//   f_out/g_out/h_out out F_W values at n_next
module babbage_step
    import babbage_pkg::*;
(
    input  logic [N_W-1:0] n_next,
    input  logic [F_W-1:0] f_in,
    input  logic [F_W-1:0] g_in,
    input  logic [F_W-1:0] h_in,
    output logic [F_W-1:0] f_out,
    output logic [F_W-1:0] g_out,
    output logic [F_W-1:0] h_out
);

    // First two steps seed g and h; later steps add the constant third difference.
    always_comb begin
        h_out = F_W'(h_in + C);
        g_out = F_W'(h_in + C + g_in);
        if (n_next == N_W'(1)) begin
            h_out = h_in;
            g_out = G1;
        end else if (n_next == N_W'(2)) begin
            h_out = H2;
            g_out = F_W'(H2 + g_in);
        end
        f_out = F_W'(g_out + f_in);
    end

endmodule

// File: rtl/babbage_inverse.sv
// Inverse difference engine: walks f(n) from n=0 one index per clock and
// stops at the first n where f(n) >= target (or n = 63).
// Build option: define BABBAGE_INV_FLOOR_EN for floor mode (largest n with
// f(n) <= target); default is ceiling mode.
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   start      in   begin a search (idle only)
//   target     in   value to invert, latched on accepted start
//   n_out      out  result index
//   exact      out  f(n_out) == target
//   range_err  out  no valid index in 0..63
//   ready      out  high in idle
//   done_tick  out  one-cycle completion pulse
module babbage_inverse
    import babbage_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [F_W-1:0] target,
    output logic [N_W-1:0] n_out,
    output logic           exact,
    output logic           range_err,
    output logic           ready,
    output logic           done_tick
);

    state_e         state_q, state_d;
    logic [F_W-1:0] target_q, target_d;
    logic [F_W-1:0] f_q, f_d, g_q, g_d, h_q, h_d;
    logic [N_W-1:0] n_q, n_d;
    logic [N_W-1:0] n_out_q, n_out_d;
    logic           exact_q, exact_d;
    logic           range_err_q, range_err_d;
    logic           ready_q, ready_d;
    logic           done_tick_q, done_tick_d;

    logic [N_W-1:0] n_inc;
    logic [F_W-1:0] f_nx, g_nx, h_nx;

    assign n_inc = N_W'(n_q + N_W'(1));

    babbage_step u_step (
        .n_next (n_inc),
        .f_in   (f_q),
        .g_in   (g_q),
        .h_in   (h_q),
        .f_out  (f_nx),
        .g_out  (g_nx),
        .h_out  (h_nx)
    );

    // Next-state and result-capture logic.
    always_comb begin
        state_d     = state_q;
        target_d    = target_q;
        f_d         = f_q;
        g_d         = g_q;
        h_d         = h_q;
        n_d         = n_q;
        n_out_d     = n_out_q;
        exact_d     = exact_q;
        range_err_d = range_err_q;
        done_tick_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    target_d = target;
                    f_d      = F0;
                    g_d      = '0;
                    h_d      = '0;
                    n_d      = '0;
                    state_d  = ST_OP;
                end
            end
            ST_OP: begin
                if ((f_q >= target_q) || (n_q == N_MAX)) begin
                    state_d     = ST_DONE;
                    done_tick_d = 1'b1;
`ifdef BABBAGE_INV_FLOOR_EN
                    if (f_q == target_q) begin
                        n_out_d     = n_q;
                        exact_d     = 1'b1;
                        range_err_d = 1'b0;
                    end else if ((f_q > target_q) && (n_q != '0)) begin
                        n_out_d     = N_W'(n_q - N_W'(1));
                        exact_d     = 1'b0;
                        range_err_d = 1'b0;
                    end else if (f_q > target_q) begin
                        // Only reachable with target 0: below f(0).
                        n_out_d     = '0;
                        exact_d     = 1'b0;
                        range_err_d = 1'b1;
                    end else begin
                        n_out_d     = n_q;
                        exact_d     = 1'b0;
                        range_err_d = 1'b0;
                    end
`else
                    n_out_d     = n_q;
                    exact_d     = (f_q == target_q);
                    range_err_d = (f_q < target_q);
`endif
                end else begin
                    n_d = n_inc;
                    f_d = f_nx;
                    g_d = g_nx;
                    h_d = h_nx;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ready_d = (state_d == ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            target_q    <= '0;
            f_q         <= '0;
            g_q         <= '0;
            h_q         <= '0;
            n_q         <= '0;
            n_out_q     <= '0;
            exact_q     <= 1'b0;
            range_err_q <= 1'b0;
            ready_q     <= 1'b1;
            done_tick_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            target_q    <= target_d;
            f_q         <= f_d;
            g_q         <= g_d;
            h_q         <= h_d;
            n_q         <= n_d;
            n_out_q     <= n_out_d;
            exact_q     <= exact_d;
            range_err_q <= range_err_d;
            ready_q     <= ready_d;
            done_tick_q <= done_tick_d;
        end
    end

    assign n_out     = n_out_q;
    assign exact     = exact_q;
    assign range_err = range_err_q;
    assign ready     = ready_q;
    assign done_tick = done_tick_q;

endmodule

// File: tb/tb_babbage_inverse.sv
// Bench for babbage_inverse: directed targets push expected results into a
// queue; a monitor pops on every done_tick and compares result and cycle.
module tb_babbage_inverse;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [17:0] target;
    logic [5:0]  n_out;
    logic        exact;
    logic        range_err;
    logic        ready;
    logic        done_tick;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        int n;
        int ex;
        int re;
        int cyc;
    } exp_t;

    exp_t sb[$];

    babbage_inverse dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .target    (target),
        .n_out     (n_out),
        .exact     (exact),
        .range_err (range_err),
        .ready     (ready),
        .done_tick (done_tick)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_ready();
        int w = 0;
        while (!ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        check("ready_return", int'(ready), 1);
    endtask

    // Called at a negedge with ready high; returns at a negedge with ready high.
    task automatic issue(input int tgt, input int k, input int en, input int eex, input int ere);
        exp_t e;
        start  = 1'b1;
        target = 18'(tgt);
        e.n = en; e.ex = eex; e.re = ere; e.cyc = cyc + k + 2;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        wait_ready();
    endtask

    // Monitor: compare each completed search against the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && done_tick) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_done: done_tick with n_out=%0d at cycle %0d, none expected", n_out, cyc);
                end else begin
                    e = sb.pop_front();
                    check("n_out", int'(n_out), e.n);
                    check("exact", int'(exact), e.ex);
                    check("range_err", int'(range_err), e.re);
                    check("done_cycle", cyc, e.cyc);
                    @(negedge clk);
                    check("ready_after_done", int'(ready), 1);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        target = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_ready", int'(ready), 1);
        check("rst_n_out", int'(n_out), 0);
        check("rst_exact", int'(exact), 0);
        check("rst_range_err", int'(range_err), 0);
        check("rst_done_tick", int'(done_tick), 0);

        // tgt, k, n_out, exact, range_err
        issue(52, 3, 3, 1, 0);
`ifdef BABBAGE_INV_FLOOR_EN
        issue(53, 4, 3, 0, 0);
`else
        issue(53, 4, 4, 0, 0);
`endif
        issue(1, 0, 0, 1, 0);
`ifdef BABBAGE_INV_FLOOR_EN
        issue(0, 0, 0, 0, 1);
`else
        issue(0, 0, 0, 0, 0);
`endif
        issue(258112, 63, 63, 1, 0);
`ifdef BABBAGE_INV_FLOOR_EN
        issue(262143, 63, 63, 0, 0);
        issue(7, 2, 1, 0, 0);
`else
        issue(262143, 63, 63, 0, 1);
        issue(7, 2, 2, 0, 0);
`endif
        issue(6, 1, 1, 1, 0);
        issue(105, 4, 4, 1, 0);

        // Start during op with a different target must be ignored.
        begin
            exp_t e;
            start  = 1'b1;
            target = 18'd21;
            e.n = 2; e.ex = 1; e.re = 0; e.cyc = cyc + 4;
            sb.push_back(e);
            @(negedge clk);
            start = 1'b0;
            @(negedge clk);
            start  = 1'b1;
            target = 18'd6;
            @(negedge clk);
            start = 1'b0;
            wait_ready();
        end

        // Reset mid-search: back to idle, outputs cleared, no completion.
        start  = 1'b1;
        target = 18'd105;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_ready", int'(ready), 1);
        check("midrst_n_out", int'(n_out), 0);
        check("midrst_exact", int'(exact), 0);
        check("midrst_range_err", int'(range_err), 0);
        check("midrst_done_tick", int'(done_tick), 0);
        rst = 1'b0;
        repeat (8) @(negedge clk);

        // Recovery after reset.
        issue(52, 3, 3, 1, 0);

        repeat (5) @(negedge clk);
        check("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
